// File: rtl/updown_sweep_ctrl.sv
// Direction controller for a 3-bit up/down counter: free up/down or ping-pong
// between LO and HI, with turnaround counting and a sticky sequence-error flag.
module updown_sweep_ctrl #(
  parameter int unsigned LO     = 0,
  parameter int unsigned HI     = 7,
  parameter int unsigned TURN_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [2:0]        count,
  input  logic              clr_err,
  output logic              up,
  output logic              turn_pulse,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam logic [2:0] LO_C = 3'(LO);
  localparam logic [2:0] HI_C = 3'(HI);

  mode_e             mode_s;
  logic [2:0]        pred;
  logic              turn;
  logic              mismatch;

  logic              up_q, up_d;
  logic              turn_pulse_q, turn_pulse_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic              seq_err_q, seq_err_d;
  logic [2:0]        exp_q, exp_d;
  logic              exp_valid_q, exp_valid_d;

  assign mode_s = mode_e'(mode);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pred = up_q ? (count + 3'd1) : (count - 3'd1);

    up_d = up_q;
    case (mode_s)
      MODE_DOWN: up_d = 1'b0;
      MODE_PING: begin
        if (pred >= HI_C)      up_d = 1'b0;
        else if (pred <= LO_C) up_d = 1'b1;
      end
      default:   up_d = 1'b1;
    endcase

    // A reversal only counts when the window logic caused it, not a mode switch.
    turn         = (mode_s == MODE_PING) && (up_d != up_q);
    turn_pulse_d = turn;
    turn_cnt_d   = turn ? (turn_cnt_q + TURN_W'(1)) : turn_cnt_q;

    exp_d       = pred;
    exp_valid_d = 1'b1;
    mismatch    = exp_valid_q && (count != exp_q);

    seq_err_d = seq_err_q;
    if (mismatch)     seq_err_d = 1'b1;
    else if (clr_err) seq_err_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, with an async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_q         <= 1'b1;
      turn_pulse_q <= 1'b0;
      turn_cnt_q   <= '0;
      seq_err_q    <= 1'b0;
      exp_q        <= 3'd0;
      exp_valid_q  <= 1'b0;
    end else begin
      up_q         <= up_d;
      turn_pulse_q <= turn_pulse_d;
      turn_cnt_q   <= turn_cnt_d;
      seq_err_q    <= seq_err_d;
      exp_q        <= exp_d;
      exp_valid_q  <= exp_valid_d;
    end
  end

  assign up         = up_q;
  assign turn_pulse = turn_pulse_q;
  assign turn_cnt   = turn_cnt_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench: three controllers (full sweep, LO=2/HI=5, LO=3/HI=4 with 2-bit
// turn counter), each closed around a behavioural 3-bit up/down counter.
module tb_updown_sweep_ctrl;

  logic       clk;
  logic       reset_n;
  logic [1:0] mode_a, mode_b, mode_c;
  logic       clr_a;
  logic       clr_none;
  logic       ovr_en;
  logic [2:0] ovr_val;

  logic [2:0] cnt_a_q, cnt_b_q, cnt_c_q;
  logic [2:0] count_a;
  logic       up_a, up_b, up_c;
  logic       tp_a, tp_b, tp_c;
  logic [7:0] tc_a, tc_b;
  logic [1:0] tc_c;
  logic       se_a, se_b, se_c;

  int vectors;
  int miscompares;

  assign count_a  = ovr_en ? ovr_val : cnt_a_q;
  assign clr_none = 1'b0;

  updown_sweep_ctrl #(.LO(0), .HI(7), .TURN_W(8)) u_a (
    .clk(clk), .reset_n(reset_n), .mode(mode_a), .count(count_a), .clr_err(clr_a),
    .up(up_a), .turn_pulse(tp_a), .turn_cnt(tc_a), .seq_err(se_a));

  updown_sweep_ctrl #(.LO(2), .HI(5), .TURN_W(8)) u_b (
    .clk(clk), .reset_n(reset_n), .mode(mode_b), .count(cnt_b_q), .clr_err(clr_none),
    .up(up_b), .turn_pulse(tp_b), .turn_cnt(tc_b), .seq_err(se_b));

  updown_sweep_ctrl #(.LO(3), .HI(4), .TURN_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .mode(mode_c), .count(cnt_c_q), .clr_err(clr_none),
    .up(up_c), .turn_pulse(tp_c), .turn_cnt(tc_c), .seq_err(se_c));

  // Attached counters; counter A reloads from the forced value when overridden.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_a_q <= 3'd0;
    else          cnt_a_q <= up_a ? count_a + 3'd1 : count_a - 3'd1;
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_b_q <= 3'd0;
    else          cnt_b_q <= up_b ? cnt_b_q + 3'd1 : cnt_b_q - 3'd1;
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_c_q <= 3'd0;
    else          cnt_c_q <= up_c ? cnt_c_q + 3'd1 : cnt_c_q - 3'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int ka, m;
    int e_cnt, e_up, e_tp, e_tc;
    vectors     = 0;
    miscompares = 0;
    reset_n = 1'b0;
    mode_a  = 2'b10;
    mode_b  = 2'b10;
    mode_c  = 2'b10;
    clr_a   = 1'b0;
    ovr_en  = 1'b0;
    ovr_val = 3'd0;

    // Reset values
    tick(2);
    check("rst_up",  32'(up_a), 1);
    check("rst_tp",  32'(tp_a), 0);
    check("rst_tc",  32'(tc_a), 0);
    check("rst_se",  32'(se_a), 0);
    reset_n = 1'b1;

    // Ping-pong sweeps: A over 0..7, B over 2..5, C reversing every cycle in 3..4
    for (int k = 1; k <= 28; k++) begin
      tick(1);
      ka    = k % 14;
      e_cnt = (ka <= 7) ? ka : 14 - ka;
      e_up  = (ka >= 7) ? 0 : 1;
      e_tp  = (ka == 7 || ka == 0) ? 1 : 0;
      check($sformatf("a_cnt@%0d", k), 32'(cnt_a_q), e_cnt);
      check($sformatf("a_up@%0d", k),  32'(up_a), e_up);
      check($sformatf("a_tp@%0d", k),  32'(tp_a), e_tp);
      check($sformatf("a_tc@%0d", k),  32'(tc_a), k / 7);
      check($sformatf("a_se@%0d", k),  32'(se_a), 0);

      if (k == 1) begin
        e_cnt = 1; e_up = 1; e_tp = 0;
      end else begin
        m = (k - 2) % 6;
        e_cnt = (m <= 3) ? 2 + m : 8 - m;
        e_up  = (m >= 3) ? 0 : 1;
        e_tp  = (m == 3 || (m == 0 && k > 2)) ? 1 : 0;
      end
      e_tc = (k < 5) ? 0 : (k - 5) / 3 + 1;
      check($sformatf("b_cnt@%0d", k), 32'(cnt_b_q), e_cnt);
      check($sformatf("b_up@%0d", k),  32'(up_b), e_up);
      check($sformatf("b_tp@%0d", k),  32'(tp_b), e_tp);
      check($sformatf("b_tc@%0d", k),  32'(tc_b), e_tc);
      check($sformatf("b_se@%0d", k),  32'(se_b), 0);

      e_cnt = (k < 3) ? k : ((k % 2) == 1 ? 3 : 4);
      e_up  = (k < 4) ? 1 : k % 2;
      e_tp  = (k >= 4) ? 1 : 0;
      e_tc  = (k < 4) ? 0 : (k - 3) % 4;
      check($sformatf("c_cnt@%0d", k), 32'(cnt_c_q), e_cnt);
      check($sformatf("c_up@%0d", k),  32'(up_c), e_up);
      check($sformatf("c_tp@%0d", k),  32'(tp_c), e_tp);
      check($sformatf("c_tc@%0d", k),  32'(tc_c), e_tc);
      check($sformatf("c_se@%0d", k),  32'(se_c), 0);
    end

    // Mode changes: one cycle of latency, never counted as turnarounds
    mode_a = 2'b00;
    mode_b = 2'b10;
    do_reset();
    tick(3);
    check("mode_up0", 32'(up_a), 1);
    check("mode_b_up0", 32'(up_b), 1);
    mode_a = 2'b01;
    mode_b = 2'b01;
    #1;
    check("mode_nocomb", 32'(up_a), 1);
    tick(1);
    check("mode_dn_up", 32'(up_a), 0);
    check("mode_dn_tp", 32'(tp_a), 0);
    check("mode_b_up",  32'(up_b), 0);
    check("mode_b_tp",  32'(tp_b), 0);
    check("mode_b_tc",  32'(tc_b), 0);
    mode_a = 2'b11;
    tick(1);
    check("mode_rsvd_up", 32'(up_a), 1);
    check("mode_rsvd_tp", 32'(tp_a), 0);
    mode_a = 2'b00;
    tick(1);
    check("mode_up_up", 32'(up_a), 1);
    check("mode_up_tc", 32'(tc_a), 0);
    check("mode_se",    32'(se_a), 0);

    // Sequence error: force count 3 while exp = 5, then clear, then clear vs mismatch
    mode_a = 2'b00;
    mode_b = 2'b10;
    do_reset();
    tick(5);
    check("err_pre_cnt", 32'(cnt_a_q), 5);
    check("err_pre_se",  32'(se_a), 0);
    ovr_en  = 1'b1;
    ovr_val = 3'd3;
    tick(1);
    ovr_en = 1'b0;
    check("err_set",     32'(se_a), 1);
    check("err_cnt",     32'(cnt_a_q), 4);
    tick(2);
    check("err_sticky",  32'(se_a), 1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("err_clr",     32'(se_a), 0);
    check("err_clr_cnt", 32'(cnt_a_q), 7);
    ovr_en  = 1'b1;
    ovr_val = 3'd3;
    clr_a   = 1'b1;
    tick(1);
    ovr_en = 1'b0;
    clr_a  = 1'b0;
    check("err_set_wins", 32'(se_a), 1);
    tick(1);
    check("err_hold",     32'(se_a), 1);

    // Reset mid-sweep at count 6 going down; first count after release unchecked
    mode_a = 2'b10;
    do_reset();
    tick(8);
    check("mid_cnt", 32'(cnt_a_q), 6);
    check("mid_up",  32'(up_a), 0);
    check("mid_tc",  32'(tc_a), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_up", 32'(up_a), 1);
    check("mid_rst_tp", 32'(tp_a), 0);
    check("mid_rst_tc", 32'(tc_a), 0);
    check("mid_rst_se", 32'(se_a), 0);
    @(negedge clk);
    reset_n = 1'b1;
    ovr_en  = 1'b1;
    ovr_val = 3'd5;
    tick(1);
    ovr_en = 1'b0;
    check("rel_se0",  32'(se_a), 0);
    check("rel_cnt",  32'(cnt_a_q), 6);
    tick(1);
    check("rel_se1",  32'(se_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
